control_fsm: RTL and testbench
==============================

# control_fsm

Multicycle control sequencer for the non-pipelined MIPS datapath. It latches the opcode and steps a one-hot 6-bit `state` through fetch, decode, execute, memory and writeback. The register file uses `state` to gate operand reads (decode) and writes (writeback). The block also drives every datapath control strobe, including `reg_write`, which feeds the register file's `RegWrite`.

## Interface
- `MEM_TIMEOUT`, 16 — cycles allowed in MEMORY before a timeout trap (used only with `MEM_TIMEOUT_EN`).
- `clk`  in  1  — single system clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `opcode`  in  6  — instruction bits [31:26] from the instruction register.
- `zero`  in  1  — ALU zero flag.
- `mem_ready`  in  1  — data-memory access complete.
- `state`  out  6  — one-hot state, fed to the register file.
- `reg_write`  out  1  — register file write enable.
- `reg_dst_rd`  out  1  — 1 = write rd, 0 = write rt.
- `alu_src_imm`  out  1  — ALU B operand = sign-extended immediate.
- `alu_op`  out  2  — 00 add, 01 sub, 10 use funct.
- `mem_read`  out  1  — data-memory read request.
- `mem_write`  out  1  — data-memory write request.
- `mem_to_reg`  out  1  — writeback data comes from memory.
- `ir_write`  out  1  — load the instruction register.
- `pc_write`  out  1  — load the PC.
- `pc_src`  out  2  — 00 PC+4, 01 branch target, 10 jump target.
- `trap`  out  1  — sticky error flag.

## Operation
- **State encodings:** FETCH=000001, DECODE=000010, EXECUTE=000100, MEMORY=001000, TRAP=010000, WRITEBACK=100000. `state` is always exactly one-hot.
- **Instruction classes:** R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- **FETCH:** `ir_write`=1, `pc_write`=1, `pc_src`=00. Next state is DECODE.
- **DECODE:** `opcode` is captured into `op_q`.
  - J: `pc_write`=1, `pc_src`=10, next FETCH.
  - R, LW, SW, BEQ, ADDI: next EXECUTE.
  - Any other opcode: next TRAP.
- **EXECUTE** (decoded from `op_q`):
  - R: `alu_op`=10, next WRITEBACK.
  - ADDI: `alu_src_imm`=1, `alu_op`=00, next WRITEBACK.
  - LW/SW: `alu_src_imm`=1, `alu_op`=00, next MEMORY.
  - BEQ: `alu_op`=01, `pc_src`=01, `pc_write`=`zero`, next FETCH.
- **MEMORY:** LW drives `mem_read`=1; SW drives `mem_write`=1. The request is held until `mem_ready`=1. In the `mem_ready` cycle, LW goes to WRITEBACK and SW goes to FETCH.
- **WRITEBACK:** `reg_write`=1.
  - R: `reg_dst_rd`=1.
  - ADDI: `reg_dst_rd`=0.
  - LW: `reg_dst_rd`=0, `mem_to_reg`=1.
  - Next state is FETCH.
- **TRAP:** `trap`=1 and all strobes are 0. The state is held until reset.
- All outputs not listed for a state are 0.

## Timing
- **Reset:** `state`=000001 (FETCH), `op_q`=0, `trap`=0. All strobes are forced to 0 while `reset` is high. Reset mid-instruction abandons the instruction; the first FETCH strobes appear in the first cycle after deassertion.
- Outputs are combinational from `state` and `op_q` (from live `opcode` in DECODE).
- **Instruction latencies (cycles):**
  - J: 2
  - BEQ: 3
  - R / ADDI: 4
  - SW: 4 + waits
  - LW: 5 + waits
- Each extra cycle with `mem_ready`=0 in MEMORY adds one cycle. `mem_ready` is ignored outside MEMORY.
- `reg_write` is high for exactly one cycle per R/ADDI/LW, and only while `state`=100000.
- `state`=000010 lasts exactly one cycle per instruction.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter clears on entry to MEMORY and increments each MEMORY cycle with `mem_ready`=0.
  - When it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is TRAP and `mem_read`/`mem_write` drop.
  - A `mem_ready` in the same cycle as the limit wins: the access completes normally.
- **Not defined:** no counter; MEMORY waits indefinitely.

## Test plan
- **Reset then ADD:** reset with `opcode`=000000 -> `state` sequence 000001, 000010, 000100, 100000, 000001; `reg_write`=1 and `reg_dst_rd`=1 only in cycle 4.
- **LW with 3 wait cycles:** `opcode`=100011, `mem_ready` low for 3 MEMORY cycles -> `mem_read`=1 for 4 cycles, then WRITEBACK with `mem_to_reg`=1 and `reg_dst_rd`=0; 8 cycles total.
- **BEQ:** with `zero`=1 -> `pc_write`=1 and `pc_src`=01 in EXECUTE. With `zero`=0 -> `pc_write`=0. Both return to FETCH, with no `reg_write`.
- **J and illegal opcode:**
  - J -> `pc_src`=10 and `pc_write`=1 in DECODE, next FETCH.
  - `opcode`=111111 -> `state`=010000 and `trap`=1, held for 20 cycles until reset.
- **Reset mid-access:** assert `reset` during SW MEMORY -> `state`=000001 immediately and `mem_write`=0 asynchronously.
- **Timeout (`MEM_TIMEOUT_EN`, `MEM_TIMEOUT`=4):** LW with `mem_ready` held 0 -> TRAP after 4 MEMORY cycles. Repeat with `mem_ready`=1 on the limit cycle -> normal WRITEBACK.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle MIPS control sequencer: one-hot state walk FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// Optional MEM_TIMEOUT_EN adds a MEMORY wait limit that traps after MEM_TIMEOUT stalled cycles.
module control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [5:0] state,
  output logic       reg_write,
  output logic       reg_dst_rd,
  output logic       alu_src_imm,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       trap
);

  typedef enum logic [5:0] {
    S_FETCH     = 6'b000001,
    S_DECODE    = 6'b000010,
    S_EXECUTE   = 6'b000100,
    S_MEMORY    = 6'b001000,
    S_TRAP      = 6'b010000,
    S_WRITEBACK = 6'b100000
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  logic       reg_write_c, reg_dst_rd_c, alu_src_imm_c, mem_read_c, mem_write_c;
  logic       mem_to_reg_c, ir_write_c, pc_write_c, trap_c;
  logic [1:0] alu_op_c, pc_src_c;
  logic       mem_timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is held at zero outside MEMORY, so it is already clear on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_MEMORY && !mem_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Limit is reached by this cycle's increment; a same-cycle mem_ready takes priority.
  assign mem_timeout = !mem_ready && (cnt_q == CW'(MEM_TIMEOUT - 1));
`else
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    reg_write_c   = 1'b0;
    reg_dst_rd_c  = 1'b0;
    alu_src_imm_c = 1'b0;
    alu_op_c      = 2'b00;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    mem_to_reg_c  = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    pc_src_c      = 2'b00;
    trap_c        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_J: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'b10;
            state_d    = S_FETCH;
          end
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: state_d = S_EXECUTE;
          default:                             state_d = S_TRAP;
        endcase
      end
      S_EXECUTE: begin
        case (op_q)
          OP_R: begin
            alu_op_c = 2'b10;
            state_d  = S_WRITEBACK;
          end
          OP_ADDI: begin
            alu_src_imm_c = 1'b1;
            state_d       = S_WRITEBACK;
          end
          OP_LW, OP_SW: begin
            alu_src_imm_c = 1'b1;
            state_d       = S_MEMORY;
          end
          OP_BEQ: begin
            alu_op_c   = 2'b01;
            pc_src_c   = 2'b01;
            pc_write_c = zero;
            state_d    = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMORY: begin
        mem_read_c  = (op_q == OP_LW);
        mem_write_c = (op_q == OP_SW);
        if (mem_ready)        state_d = (op_q == OP_LW) ? S_WRITEBACK : S_FETCH;
        else if (mem_timeout) state_d = S_TRAP;
      end
      S_WRITEBACK: begin
        reg_write_c  = 1'b1;
        reg_dst_rd_c = (op_q == OP_R);
        mem_to_reg_c = (op_q == OP_LW);
        state_d      = S_FETCH;
      end
      S_TRAP:  trap_c  = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  // State snaps to FETCH asynchronously on reset, so strobes are masked to stay quiet meanwhile.
  assign state       = state_q;
  assign reg_write   = reg_write_c   & ~reset;
  assign reg_dst_rd  = reg_dst_rd_c  & ~reset;
  assign alu_src_imm = alu_src_imm_c & ~reset;
  assign alu_op      = alu_op_c      & {2{~reset}};
  assign mem_read    = mem_read_c    & ~reset;
  assign mem_write   = mem_write_c   & ~reset;
  assign mem_to_reg  = mem_to_reg_c  & ~reset;
  assign ir_write    = ir_write_c    & ~reset;
  assign pc_write    = pc_write_c    & ~reset;
  assign pc_src      = pc_src_c      & {2{~reset}};
  assign trap        = trap_c        & ~reset;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm; every output is compared as one packed vector per cycle.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic [5:0] state;
  logic       reg_write, reg_dst_rd, alu_src_imm, mem_read, mem_write, mem_to_reg;
  logic       ir_write, pc_write, trap;
  logic [1:0] alu_op, pc_src;

  int checks = 0;
  int errors = 0;

  control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .reg_write(reg_write), .reg_dst_rd(reg_dst_rd),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .trap(trap)
  );

  always #5 clk = ~clk;

  // Field order: state, rw, rd, imm, aluop, mr, mw, m2r, irw, pcw, pcsrc, trap
  function automatic logic [18:0] e(logic [5:0] st, logic rw, logic rd, logic imm,
                                    logic [1:0] aop, logic mr, logic mw, logic m2r,
                                    logic irw, logic pcw, logic [1:0] ps, logic tr);
    return {st, rw, rd, imm, aop, mr, mw, m2r, irw, pcw, ps, tr};
  endfunction

  localparam logic [18:0] E_FETCH = 19'({6'h01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0});
  localparam logic [18:0] E_DEC   = 19'({6'h02, 13'b0});
  localparam logic [18:0] E_RST   = 19'({6'h01, 13'b0});

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = {state, reg_write, reg_dst_rd, alu_src_imm, alu_op, mem_read, mem_write,
           mem_to_reg, ir_write, pc_write, pc_src, trap};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    cyc(); #1 chk("reset_hold", E_RST);
    cyc(); reset = 1'b0; #1 chk("r_fetch", E_FETCH);

    // R-type: 4 cycles, reg_write with rd only in WRITEBACK
    cyc(); #1 chk("r_decode", E_DEC);
    cyc(); #1 chk("r_exec", e(6'h04, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0));
    cyc(); #1 chk("r_wb", e(6'h20, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    cyc(); opcode = 6'b100011; #1 chk("lw_fetch", E_FETCH);

    // LW with 3 wait cycles: 8 cycles total
    cyc(); #1 chk("lw_decode", E_DEC);
    cyc(); opcode = 6'b111111; #1 chk("lw_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(); #1 chk("lw_mem_wait", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    end
    cyc(); mem_ready = 1'b1; #1 chk("lw_mem_ready", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    cyc(); mem_ready = 1'b0; #1 chk("lw_wb", e(6'h20, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0));
    cyc(); opcode = 6'b000100; zero = 1'b1; #1 chk("beq1_fetch", E_FETCH);

    // BEQ taken then not taken
    cyc(); #1 chk("beq1_decode", E_DEC);
    cyc(); #1 chk("beq1_exec", e(6'h04, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 2'b01, 0));
    cyc(); zero = 1'b0; #1 chk("beq0_fetch", E_FETCH);
    cyc(); #1 chk("beq0_decode", E_DEC);
    cyc(); #1 chk("beq0_exec", e(6'h04, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b01, 0));

    // SW with mem_ready high throughout: ignored until MEMORY, completes in one cycle
    cyc(); opcode = 6'b101011; mem_ready = 1'b1; #1 chk("sw_fetch", E_FETCH);
    cyc(); #1 chk("sw_decode", E_DEC);
    cyc(); #1 chk("sw_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    cyc(); #1 chk("sw_mem", e(6'h08, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0));
    cyc(); opcode = 6'b001000; mem_ready = 1'b0; #1 chk("addi_fetch", E_FETCH);

    // ADDI
    cyc(); #1 chk("addi_decode", E_DEC);
    cyc(); #1 chk("addi_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    cyc(); #1 chk("addi_wb", e(6'h20, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    cyc(); opcode = 6'b000010; #1 chk("j_fetch", E_FETCH);

    // J: 2 cycles
    cyc(); #1 chk("j_decode", e(6'h02, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0));
    cyc(); opcode = 6'b101011; #1 chk("sw2_fetch", E_FETCH);

    // Reset during SW MEMORY
    cyc(); #1 chk("sw2_decode", E_DEC);
    cyc(); #1 chk("sw2_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    cyc(); #1 chk("sw2_mem", e(6'h08, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0));
    reset = 1'b1; #1 chk("sw2_async_reset", E_RST);
    cyc(); reset = 1'b0; opcode = 6'b111111; #1 chk("ill_fetch", E_FETCH);

    // Illegal opcode traps and holds
    cyc(); #1 chk("ill_decode", E_DEC);
    for (int i = 0; i < 20; i++) begin
      cyc(); opcode = 6'(i); mem_ready = i[0]; zero = i[1];
      #1 chk("ill_trap_hold", e(6'h10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1));
    end
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; #1 chk("trap_reset", E_RST);
    cyc(); reset = 1'b0; opcode = 6'b000000; #1 chk("post_trap_fetch", E_FETCH);
    cyc(); #1 chk("post_trap_decode", E_DEC);

`ifdef MEM_TIMEOUT_EN
    // LW stalled: TRAP after 4 MEMORY cycles
    cyc(); #1;
    cyc(); #1;
    cyc(); opcode = 6'b100011; #1 chk("to_fetch", E_FETCH);
    cyc(); #1 chk("to_decode", E_DEC);
    cyc(); #1 chk("to_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    for (int i = 0; i < 4; i++) begin
      cyc(); #1 chk("to_mem", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    end
    cyc(); #1 chk("to_trap", e(6'h10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1));
    reset = 1'b1; #1 chk("to_reset", E_RST);
    cyc(); reset = 1'b0; #1 chk("to2_fetch", E_FETCH);
    cyc(); #1 chk("to2_decode", E_DEC);
    cyc(); #1 chk("to2_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(); #1 chk("to2_mem", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    end
    cyc(); mem_ready = 1'b1; #1 chk("to2_mem_limit", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    cyc(); mem_ready = 1'b0; #1 chk("to2_wb", e(6'h20, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0));
    cyc(); #1 chk("to2_fetch_end", E_FETCH);
`else
    // Without the timeout an LW waits indefinitely in MEMORY
    cyc(); #1;
    cyc(); #1;
    cyc(); opcode = 6'b100011; #1 chk("nt_fetch", E_FETCH);
    cyc(); #1 chk("nt_decode", E_DEC);
    cyc(); #1 chk("nt_exec", e(6'h04, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
    for (int i = 0; i < 24; i++) begin
      cyc(); #1 chk("nt_mem_wait", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    end
    cyc(); mem_ready = 1'b1; #1 chk("nt_mem_ready", e(6'h08, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0));
    cyc(); mem_ready = 1'b0; #1 chk("nt_wb", e(6'h20, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0));
    cyc(); #1 chk("nt_fetch_end", E_FETCH);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
